if_fetch_unit: RTL and testbench

Instruction-fetch stage and producer side of the IF/ID pipeline register. It owns the PC and issues one-outstanding-request fetches to instruction memory over a variable-latency req/ack handshake. Each fetched word is presented on IR with a valid flag. It honours the downstream wait_ID stall through a one-entry skid buffer, and it flushes on a branch/jump redirect so that IF/ID only ever captures in-order instructions.

---
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a req/ack handshake,
// and drives the IF/ID register through a one-entry skid buffer with redirect flushing.
module if_fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     IR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wait_ID,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [IR_W-1:0] IR,
  output logic [PC_W-1:0] pc_out,
  output logic            ir_valid
);

  typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

  state_e          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [PC_W-1:0] r_flush_addr, w_flush_addr_next;
  logic [IR_W-1:0] r_ir, w_ir_next;
  logic [PC_W-1:0] r_pc_out, w_pc_out_next;
  logic            r_ir_valid, w_ir_valid_next;
  logic [IR_W-1:0] r_skid_ir, w_skid_ir_next;
  logic [PC_W-1:0] r_skid_pc, w_skid_pc_next;
  logic            r_skid_valid, w_skid_valid_next;
  logic            w_ack_busy;
  logic            w_out_free;

  assign w_ack_busy = (r_state == StBusy) && imem_ack;
  assign w_out_free = !r_ir_valid || !wait_ID;

  assign imem_req  = (r_state != StIdle);
  assign imem_addr = (r_state == StFlush) ? r_flush_addr : r_pc;
  assign IR        = r_ir;
  assign pc_out    = r_pc_out;
  assign ir_valid  = r_ir_valid;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_flush_addr_next = r_flush_addr;
    w_ir_next         = r_ir;
    w_pc_out_next     = r_pc_out;
    w_ir_valid_next   = r_ir_valid;
    w_skid_ir_next    = r_skid_ir;
    w_skid_pc_next    = r_skid_pc;
    w_skid_valid_next = r_skid_valid;

    if (redirect) begin
      w_ir_next         = '0;
      w_ir_valid_next   = 1'b0;
      w_skid_valid_next = 1'b0;
      w_pc_next         = redirect_pc;
      // An unanswered request must still be completed, so its reply is parked in FLUSH.
      case (r_state)
        StBusy: begin
          if (!imem_ack) begin
            w_state_next      = StFlush;
            w_flush_addr_next = r_pc;
          end
        end
        StFlush: if (imem_ack) w_state_next = StBusy;
        default: w_state_next = StBusy;
      endcase
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          w_ir_next         = r_skid_ir;
          w_pc_out_next     = r_skid_pc;
          w_ir_valid_next   = 1'b1;
          w_skid_valid_next = 1'b0;
        end else if (w_ack_busy) begin
          w_ir_next       = imem_rdata;
          w_pc_out_next   = r_pc;
          w_ir_valid_next = 1'b1;
        end else begin
          w_ir_next       = '0;
          w_ir_valid_next = 1'b0;
        end
      end
      if (w_ack_busy && (!w_out_free || r_skid_valid)) begin
        w_skid_ir_next    = imem_rdata;
        w_skid_pc_next    = r_pc;
        w_skid_valid_next = 1'b1;
      end

      case (r_state)
        StIdle: if (!w_skid_valid_next) w_state_next = StBusy;
        StBusy: begin
          if (imem_ack) begin
            w_pc_next    = r_pc + PC_W'(PC_STEP);
            w_state_next = w_skid_valid_next ? StIdle : StBusy;
          end
        end
        StFlush: if (imem_ack) w_state_next = StBusy;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_flush_addr <= '0;
      r_ir         <= '0;
      r_pc_out     <= '0;
      r_ir_valid   <= 1'b0;
      r_skid_ir    <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_flush_addr <= w_flush_addr_next;
      r_ir         <= w_ir_next;
      r_pc_out     <= w_pc_out_next;
      r_ir_valid   <= w_ir_valid_next;
      r_skid_ir    <= w_skid_ir_next;
      r_skid_pc    <= w_skid_pc_next;
      r_skid_valid <= w_skid_valid_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run scored against an in-order
// stream model (each accepted word must be the next address in program order).
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, wait_ID, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IR, pc_out;
  logic        ir_valid;

  int n_pass  = 0;
  int n_total = 0;
  int mem_lat = 0;
  bit mem_rand = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .PC_W    (32),
    .IR_W    (32),
    .RESET_PC(RST_PC),
    .PC_STEP (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wait_ID    (wait_ID),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IR         (IR),
    .pc_out     (pc_out),
    .ir_valid   (ir_valid)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h0000_A5A5;
  endfunction

  // Instruction memory: acks a request after a per-request latency, junk data otherwise.
  initial begin : mem_model
    bit          prev_req;
    bit          prev_ack;
    logic [31:0] prev_addr;
    int          cnt;
    int          lat;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; cnt = 0; lat = 0;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (prev_req && !prev_ack) begin
          n_total++;
          if (imem_addr !== prev_addr)
            $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, prev_addr);
          else n_pass++;
        end else begin
          lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
          cnt = 0;
        end
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = word_at(imem_addr);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          cnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
      prev_req  = (imem_req === 1'b1);
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wait_ID = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_rand = 1'b0; mem_lat = 0;
    reset = 1'b1; wait_ID = 1'b0; redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", ir_valid);
    else n_pass++;
    n_total++;
    if (IR !== 32'h0) $display("FAIL reset_ir: got %h required 0", IR);
    else n_pass++;
    n_total++;
    if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h required 0", pc_out);
    else n_pass++;
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b required 0", imem_req);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ea = RST_PC + 32'(4 * k);
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== ea)
        $display("FAIL stream_req[%0d]: req=%b addr=%h required 1/%h", k, imem_req, imem_addr, ea);
      else n_pass++;
      n_total++;
      if (k == 0) begin
        if (ir_valid !== 1'b0) $display("FAIL stream_first_valid: got %b required 0", ir_valid);
        else n_pass++;
      end else begin
        ea = ea - 32'd4;
        if (ir_valid !== 1'b1 || pc_out !== ea || IR !== word_at(ea))
          $display("FAIL stream_ir[%0d]: v=%b pc=%h ir=%h required 1/%h/%h",
                   k, ir_valid, pc_out, IR, ea, word_at(ea));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ea;
    wait_ID = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_total++;
      if (ir_valid !== 1'b1 || pc_out !== 32'h104 || IR !== word_at(32'h104) || imem_req !== 1'b0)
        $display("FAIL stall_hold[%0d]: v=%b pc=%h ir=%h req=%b required 1/104/%h/0",
                 j, ir_valid, pc_out, IR, imem_req, word_at(32'h104));
      else n_pass++;
    end
    wait_ID = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      ea = 32'h108 + 32'(4 * j);
      n_total++;
      if (ir_valid !== 1'b1 || pc_out !== ea || IR !== word_at(ea))
        $display("FAIL stall_release[%0d]: v=%b pc=%h ir=%h required 1/%h/%h",
                 j, ir_valid, pc_out, IR, ea, word_at(ea));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_flush();
    bit found;
    bit got;
    bit seen_new;
    mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 32'h108) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL flush_find_108: got no request required req@108");
    else n_pass++;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    n_total++;
    if (ir_valid !== 1'b0 || IR !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h108)
      $display("FAIL flush_after: v=%b ir=%h req=%b addr=%h required 0/0/1/108",
               ir_valid, IR, imem_req, imem_addr);
    else n_pass++;
    got = 1'b0; seen_new = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ir_valid === 1'b1) got = 1'b1;
      if (!seen_new && imem_req === 1'b1 && imem_addr !== 32'h108) begin
        seen_new = 1'b1;
        n_total++;
        if (imem_addr !== 32'h400) $display("FAIL flush_next_req: got %h required 400", imem_addr);
        else n_pass++;
      end
    end
    n_total++;
    if (!got || pc_out !== 32'h400 || IR !== word_at(32'h400))
      $display("FAIL flush_first_ir: v=%b pc=%h ir=%h required 1/400/%h",
               got, pc_out, IR, word_at(32'h400));
    else n_pass++;
    mem_lat = 0;
  endtask

  task automatic test_redirect_stall();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    wait_ID = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h800;
    @(negedge clk);
    redirect = 1'b0;
    n_total++;
    if (ir_valid !== 1'b0 || IR !== 32'h0 || imem_addr !== 32'h800)
      $display("FAIL rs_skid_flush: v=%b ir=%h addr=%h required 0/0/800", ir_valid, IR, imem_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b1 || pc_out !== 32'h800 || IR !== word_at(32'h800))
      $display("FAIL rs_first_800: v=%b pc=%h ir=%h required 1/800/%h",
               ir_valid, pc_out, IR, word_at(32'h800));
    else n_pass++;
    wait_ID = 1'b0;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b1 || pc_out !== 32'h804 || IR !== word_at(32'h804))
      $display("FAIL rs_next_804: v=%b pc=%h ir=%h required 1/804/%h",
               ir_valid, pc_out, IR, word_at(32'h804));
    else n_pass++;
    // Output full, stalled, and the ack for 0x808 lands with the redirect.
    wait_ID = 1'b1; redirect = 1'b1; redirect_pc = 32'hC00;
    @(negedge clk);
    redirect = 1'b0;
    n_total++;
    if (ir_valid !== 1'b0 || IR !== 32'h0 || imem_addr !== 32'hC00)
      $display("FAIL rs_ack_flush: v=%b ir=%h addr=%h required 0/0/C00", ir_valid, IR, imem_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b1 || pc_out !== 32'hC00 || IR !== word_at(32'hC00))
      $display("FAIL rs_first_C00: v=%b pc=%h ir=%h required 1/C00/%h",
               ir_valid, pc_out, IR, word_at(32'hC00));
    else n_pass++;
    wait_ID = 1'b0;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b1 || pc_out !== 32'hC04 || IR !== word_at(32'hC04))
      $display("FAIL rs_next_C04: v=%b pc=%h ir=%h required 1/C04/%h",
               ir_valid, pc_out, IR, word_at(32'hC04));
    else n_pass++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    n_total++;
    if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req0: got %h required FFFFFFFC", imem_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (imem_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req1: addr=%h pc_out=%h required 0/FFFFFFFC", imem_addr, pc_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b1 || pc_out !== 32'h0 || IR !== word_at(32'h0))
      $display("FAIL wrap_ir: v=%b pc=%h ir=%h required 1/0/%h", ir_valid, pc_out, IR, word_at(0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wait_ID = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b0 || IR !== 32'h0 || imem_req !== 1'b0 || pc_out !== 32'h0)
      $display("FAIL rst_mid: v=%b ir=%h req=%b pc=%h required 0/0/0/0",
               ir_valid, IR, imem_req, pc_out);
    else n_pass++;
    reset = 1'b0; wait_ID = 1'b0;
    @(negedge clk);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      $display("FAIL rst_mid_req: req=%b addr=%h required 1/%h", imem_req, imem_addr, RST_PC);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ir_valid !== 1'b1 || pc_out !== RST_PC || IR !== word_at(RST_PC))
      $display("FAIL rst_mid_ir: v=%b pc=%h ir=%h required 1/%h/%h",
               ir_valid, pc_out, IR, RST_PC, word_at(RST_PC));
    else n_pass++;
  endtask

  // Every word ID accepts must be the next program-order address; a redirect restarts the order.
  task automatic test_random();
    logic [31:0] exp_addr;
    logic [31:0] tgt;
    bit          w;
    bit          r;
    bit          post_redirect;
    int          idle_cnt;
    bit          stop;
    mem_rand = 1'b1;
    do_reset();
    exp_addr = RST_PC; post_redirect = 1'b0; idle_cnt = 0; stop = 1'b0; tgt = '0;
    for (int c = 0; c < 3000 && !stop; c++) begin
      @(negedge clk);
      if (ir_valid === 1'b0 && IR !== 32'h0) begin
        n_total++;
        $display("FAIL rnd_ir_zero: ir=%h required 0 at cycle %0d", IR, c);
      end
      if (post_redirect) begin
        n_total++;
        if (ir_valid !== 1'b0) $display("FAIL rnd_redirect_clear: v=%b required 0", ir_valid);
        else n_pass++;
      end
      post_redirect = 1'b0;
      w = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 19) == 0);
      if (ir_valid === 1'b1 && !w) begin
        n_total++;
        if (pc_out !== exp_addr || IR !== word_at(exp_addr))
          $display("FAIL rnd_order: pc=%h ir=%h required %h/%h at cycle %0d",
                   pc_out, IR, exp_addr, word_at(exp_addr), c);
        else n_pass++;
        exp_addr = exp_addr + 32'd4;
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
      if (idle_cnt > 60) begin
        n_total++;
        $display("FAIL rnd_progress: no word accepted for %0d cycles required <= 60", idle_cnt);
        stop = 1'b1;
      end
      if (r) begin
        tgt = $urandom & 32'hFFFF_FFFC;
        exp_addr = tgt;
        post_redirect = 1'b1;
      end
      wait_ID = w; redirect = r; redirect_pc = tgt;
    end
    @(negedge clk);
    wait_ID = 1'b0; redirect = 1'b0;
    mem_rand = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wait_ID = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
